// File: rtl/elevator_pkg.sv
// Shared types, default parameters and call-search helper for the SCAN elevator controller.
package elevator_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MOVE_UP,
      ST_MOVE_DOWN,
      ST_DOOR_OPEN,
      ST_HALT_WEIGHT,
      ST_RESCUE
   } state_t;

   localparam int MAX_FLOORS       = 16;
   localparam int DEF_NUM_FLOORS   = 8;
   localparam int DEF_FLOOR_W      = 4;
   localparam int DEF_TICK_DIV     = 25000000;
   localparam int DEF_TRAVEL_TICKS = 1;
   localparam int DEF_DOOR_TICKS   = 3;

   // True when any call lies strictly above (above=1) or strictly below (above=0) the given floor.
   function automatic logic calls_beyond(input logic [MAX_FLOORS-1:0] calls,
                                         input int                    floor,
                                         input logic                  above);
      logic [MAX_FLOORS-1:0] mask;
      for (int i = 0; i < MAX_FLOORS; i++) begin
         mask[i] = above ? (i > floor) : (i < floor);
      end
      return |(calls & mask);
   endfunction

endpackage

// File: rtl/elevator_tick_gen.sv
// Free-running prescaler: one-clk tick every TICK_DIV clocks, counting from reset.
module elevator_tick_gen
   import elevator_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int            CW   = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count_reg;

   // Count 0..TICK_DIV-1 and wrap; never resynchronised by anything but reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (count_reg == LAST) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign tick = (count_reg == LAST);

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN-ordered elevator controller with timed door, over-weight hold and rescue override.
module elevator_scan_ctrl
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS   = DEF_NUM_FLOORS,
   parameter int FLOOR_W      = DEF_FLOOR_W,
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int TRAVEL_TICKS = DEF_TRAVEL_TICKS,
   parameter int DOOR_TICKS   = DEF_DOOR_TICKS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  on,
   input  logic                  req_valid,
   input  logic [FLOOR_W-1:0]    req_floor,
   input  logic                  over_weight,
   input  logic                  rescue,
   output logic [FLOOR_W-1:0]    current_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  up,
   output logic                  down,
   output logic                  open_door,
   output logic                  weight_alert,
   output logic                  responce_rescue
);

   localparam int                 TW          = $clog2(TRAVEL_TICKS + 1);
   localparam int                 DW          = $clog2(DOOR_TICKS + 1);
   localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
   localparam logic [DW-1:0]      DOOR_LAST   = DW'(DOOR_TICKS - 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

   state_t                  state_reg, state_next;
   logic [FLOOR_W-1:0]      floor_reg, floor_next;
   logic [NUM_FLOORS-1:0]   pending_reg, pending_next;
   logic                    dir_up_reg, dir_up_next;
   logic [TW-1:0]           travel_reg, travel_next;
   logic [DW-1:0]           door_reg, door_next;
   logic                    up_reg, down_reg, open_reg, weight_reg, rescue_reg;

   logic                    tick;
   logic [FLOOR_W-1:0]      floor_above, floor_below;
   logic [NUM_FLOORS-1:0]   cur_hot, above_hot, below_hot, req_hot;
   logic [NUM_FLOORS-1:0]   set_mask, clr_mask;
   logic                    req_ok, req_here, here_called, call_ahead, call_behind;

   elevator_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // Neighbouring floors saturate at the shaft ends so the position can never wrap.
   assign floor_above = (floor_reg == TOP_FLOOR) ? floor_reg : floor_reg + 1'b1;
   assign floor_below = (floor_reg == '0)        ? floor_reg : floor_reg - 1'b1;

   // One-hot floor decodes; an out-of-range req_floor matches no bit and is dropped.
   generate
      for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor_dec
         assign cur_hot[gi]   = (floor_reg   == FLOOR_W'(gi));
         assign above_hot[gi] = (floor_above == FLOOR_W'(gi));
         assign below_hot[gi] = (floor_below == FLOOR_W'(gi));
         assign req_hot[gi]   = (req_floor   == FLOOR_W'(gi));
      end
   endgenerate

   // Requests are blocked when disabled, in rescue, or when rescue is being entered this clk.
   assign req_ok      = req_valid && on && (state_reg != ST_RESCUE) && !rescue;
   assign req_here    = req_ok && (req_floor == floor_reg);
   assign here_called = |(pending_reg & cur_hot);
   assign call_ahead  = calls_beyond(MAX_FLOORS'(pending_reg), int'(floor_reg), dir_up_reg);
   assign call_behind = calls_beyond(MAX_FLOORS'(pending_reg), int'(floor_reg), !dir_up_reg);

   // Next-state, position, timer and call-vector logic; rescue overrides everything at the end.
   always_comb begin
      state_next  = state_reg;
      floor_next  = floor_reg;
      dir_up_next = dir_up_reg;
      travel_next = travel_reg;
      door_next   = door_reg;
      set_mask    = req_ok ? req_hot : '0;
      clr_mask    = '0;

      case (state_reg)
         ST_IDLE: begin
            if (on) begin
               if (over_weight) begin
                  state_next = ST_HALT_WEIGHT;
               end else if (here_called) begin
                  state_next = ST_DOOR_OPEN;
                  clr_mask   = cur_hot;
                  door_next  = '0;
               end else if (call_ahead) begin
                  state_next  = dir_up_reg ? ST_MOVE_UP : ST_MOVE_DOWN;
                  travel_next = '0;
               end else if (call_behind) begin
                  dir_up_next = !dir_up_reg;
                  state_next  = dir_up_reg ? ST_MOVE_DOWN : ST_MOVE_UP;
                  travel_next = '0;
               end
            end
         end
         ST_MOVE_UP: begin
            if (tick) begin
               if (travel_reg == TRAVEL_LAST) begin
                  travel_next = '0;
                  floor_next  = floor_above;
                  if (|(pending_reg & above_hot)) begin
                     state_next = ST_DOOR_OPEN;
                     clr_mask   = above_hot;
                     door_next  = '0;
                  end else if (floor_reg == TOP_FLOOR) begin
                     // Nothing left to reach at the top: park instead of pushing on the end stop.
                     state_next = ST_IDLE;
                  end
               end else begin
                  travel_next = travel_reg + 1'b1;
               end
            end
         end
         ST_MOVE_DOWN: begin
            if (tick) begin
               if (travel_reg == TRAVEL_LAST) begin
                  travel_next = '0;
                  floor_next  = floor_below;
                  if (|(pending_reg & below_hot)) begin
                     state_next = ST_DOOR_OPEN;
                     clr_mask   = below_hot;
                     door_next  = '0;
                  end else if (floor_reg == '0) begin
                     state_next = ST_IDLE;
                  end
               end else begin
                  travel_next = travel_reg + 1'b1;
               end
            end
         end
         ST_DOOR_OPEN: begin
            // A call for the floor we are standing at is absorbed by the open door.
            if (req_here) begin
               set_mask = '0;
            end
            if (over_weight) begin
               state_next = ST_HALT_WEIGHT;
            end else if (req_here) begin
               door_next = '0;
            end else if (tick) begin
               if (door_reg == DOOR_LAST) begin
                  state_next = ST_IDLE;
                  door_next  = '0;
               end else begin
                  door_next = door_reg + 1'b1;
               end
            end
         end
         ST_HALT_WEIGHT: begin
            if (req_here) begin
               set_mask = '0;
            end
            if (!over_weight) begin
               state_next = ST_DOOR_OPEN;
               door_next  = '0;
            end
         end
         ST_RESCUE: begin
            if (!rescue) begin
               state_next  = ST_IDLE;
               travel_next = '0;
               door_next   = '0;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Clearing a bit on door opening wins over a same-cycle request for that floor.
      pending_next = (pending_reg | set_mask) & ~clr_mask;

      if (rescue) begin
         state_next   = ST_RESCUE;
         pending_next = '0;
         floor_next   = floor_reg;
         dir_up_next  = dir_up_reg;
         travel_next  = '0;
         door_next    = '0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Position, call vector, direction and timers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         floor_reg   <= '0;
         pending_reg <= '0;
         dir_up_reg  <= 1'b1;
         travel_reg  <= '0;
         door_reg    <= '0;
      end else begin
         floor_reg   <= floor_next;
         pending_reg <= pending_next;
         dir_up_reg  <= dir_up_next;
         travel_reg  <= travel_next;
         door_reg    <= door_next;
      end
   end

   // Status flags registered from the upcoming state so they line up with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         up_reg     <= 1'b0;
         down_reg   <= 1'b0;
         open_reg   <= 1'b0;
         weight_reg <= 1'b0;
         rescue_reg <= 1'b0;
      end else begin
         up_reg     <= (state_next == ST_MOVE_UP);
         down_reg   <= (state_next == ST_MOVE_DOWN);
         open_reg   <= (state_next == ST_DOOR_OPEN) || (state_next == ST_HALT_WEIGHT);
         weight_reg <= (state_next == ST_HALT_WEIGHT);
         rescue_reg <= (state_next == ST_RESCUE);
      end
   end

   assign current_floor   = floor_reg;
   assign pending         = pending_reg;
   assign up              = up_reg;
   assign down            = down_reg;
   assign open_door       = open_reg;
   assign weight_alert    = weight_reg;
   assign responce_rescue = rescue_reg;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scoreboard bench for elevator_scan_ctrl: expected stop floors are queued as calls are
// placed and popped each time the door opens; direct checks cover flags and timing.
module tb_elevator_scan_ctrl;

   localparam int NF = 8;
   localparam int FW = 4;

   localparam int W_DOOR  = 0;
   localparam int W_IDLE  = 1;
   localparam int W_UP    = 2;
   localparam int W_FLOOR = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          on = 1'b0;
   logic          req_valid = 1'b0;
   logic [FW-1:0] req_floor = '0;
   logic          over_weight = 1'b0;
   logic          rescue = 1'b0;
   logic [FW-1:0] current_floor;
   logic [NF-1:0] pending;
   logic          up, down, open_door, weight_alert, responce_rescue;
   logic [4:0]    flags;

   int            n_checks = 0;
   int            n_fail = 0;
   int            stop_q[$];
   bit            mon_en = 1'b0;
   logic [FW-1:0] prev_floor = '0;
   logic          prev_up = 1'b0;
   logic          prev_down = 1'b0;
   logic          prev_open = 1'b0;

   elevator_scan_ctrl #(
      .NUM_FLOORS   (NF),
      .FLOOR_W      (FW),
      .TICK_DIV     (4),
      .TRAVEL_TICKS (1),
      .DOOR_TICKS   (3)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .on              (on),
      .req_valid       (req_valid),
      .req_floor       (req_floor),
      .over_weight     (over_weight),
      .rescue          (rescue),
      .current_floor   (current_floor),
      .pending         (pending),
      .up              (up),
      .down            (down),
      .open_door       (open_door),
      .weight_alert    (weight_alert),
      .responce_rescue (responce_rescue)
   );

   assign flags = {up, down, open_door, weight_alert, responce_rescue};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Called at a negedge; holds the strobe for exactly one rising edge.
   task automatic send_req(input int f);
      req_floor = FW'(f);
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      $display("[%0t] request floor %0d (cabin at %0d, pending 0x%0h)", $time, f, current_floor, pending);
   endtask

   task automatic wait_cond(input string tag, input int kind, input int arg, input int max_cyc);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         case (kind)
            W_DOOR:  ok = open_door;
            W_IDLE:  ok = (pending == '0) && !up && !down && !open_door && !weight_alert;
            W_UP:    ok = up;
            default: ok = (32'(current_floor) == arg);
         endcase
         if (ok) break;
         @(negedge clk);
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   task automatic count_open(output int n);
      n = 0;
      while (open_door && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   // Monitor: floor moves one step in the flagged direction; each door opening pops a stop.
   always @(negedge clk) begin
      int exp_f;
      if (mon_en) begin
         if (current_floor != prev_floor) begin
            if (prev_up)
               check("step_up", 32'(current_floor), 32'(prev_floor) + 32'd1);
            else if (prev_down)
               check("step_down", 32'(current_floor), 32'(prev_floor) - 32'd1);
            else
               check("step_while_parked", 32'(current_floor), 32'(prev_floor));
         end
         if (open_door && !prev_open) begin
            check("stop_expected", 32'(stop_q.size() != 0), 32'd1);
            if (stop_q.size() != 0) begin
               exp_f = stop_q.pop_front();
               $display("[%0t] door opens at floor %0d (expected %0d)", $time, current_floor, exp_f);
               check("stop_floor", 32'(current_floor), 32'(exp_f));
            end
         end
      end
      prev_floor <= current_floor;
      prev_up    <= up;
      prev_down  <= down;
      prev_open  <= open_door;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_floor", 32'(current_floor), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      reset = 1'b0;
      on    = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      // Single trip 0 -> 5
      stop_q.push_back(5);
      send_req(5);
      check("trip_pending", 32'(pending), 32'h20);
      check("trip_up_early", 32'(up), 32'd0);
      @(negedge clk);
      check("trip_up_latency", 32'(up), 32'd1);
      wait_cond("trip_door", W_DOOR, 0, 60);
      count_open(n);
      check("trip_door_len", 32'(n), 32'd12);
      check("trip_pending_clr", 32'(pending), 32'd0);
      check("trip_idle_flags", 32'(flags), 32'd0);

      // SCAN ordering: park at 2, head up for 6, add 4 and 1 on the way
      stop_q.push_back(2);
      send_req(2);
      wait_cond("scan_park", W_IDLE, 0, 200);
      check("scan_at2", 32'(current_floor), 32'd2);
      stop_q.push_back(4);
      stop_q.push_back(6);
      stop_q.push_back(1);
      send_req(6);
      wait_cond("scan_up", W_UP, 0, 10);
      check("scan_start", 32'(current_floor), 32'd2);
      send_req(4);
      send_req(1);
      check("scan_pending", 32'(pending), 32'h52);
      wait_cond("scan_done", W_IDLE, 0, 400);
      check("scan_end_floor", 32'(current_floor), 32'd1);

      // Over-weight hold during the door cycle at floor 3
      stop_q.push_back(3);
      send_req(3);
      wait_cond("ow_door", W_DOOR, 0, 60);
      check("ow_floor", 32'(current_floor), 32'd3);
      @(negedge clk);
      over_weight = 1'b1;
      @(negedge clk);
      check("ow_flags", 32'(flags), 32'b00110);
      repeat (20) @(negedge clk);
      check("ow_hold", 32'(flags), 32'b00110);
      over_weight = 1'b0;
      @(negedge clk);
      check("ow_release", 32'(flags), 32'b00100);
      count_open(n);
      $display("[%0t] door open %0d clks after weight release", $time, n);
      check("ow_door_len_in_9_12", 32'(n >= 9 && n <= 12), 32'd1);
      wait_cond("ow_idle", W_IDLE, 0, 20);

      // Rescue while moving up from 3 toward 7; simultaneous request must be lost
      send_req(7);
      wait_cond("rsc_up", W_UP, 0, 10);
      check("rsc_floor_pre", 32'(current_floor), 32'd3);
      rescue    = 1'b1;
      req_floor = 4'd5;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check("rsc_flags", 32'(flags), 32'b00001);
      check("rsc_pending", 32'(pending), 32'd0);
      check("rsc_floor", 32'(current_floor), 32'd3);
      send_req(2);
      check("rsc_req_ignored", 32'(pending), 32'd0);
      repeat (8) @(negedge clk);
      rescue = 1'b0;
      @(negedge clk);
      check("rsc_exit_flags", 32'(flags), 32'd0);
      repeat (20) @(negedge clk);
      check("rsc_idle_floor", 32'(current_floor), 32'd3);
      check("rsc_idle_flags", 32'(flags), 32'd0);

      // Out-of-range request is ignored
      send_req(9);
      @(negedge clk);
      check("oor_pending", 32'(pending), 32'd0);
      check("oor_flags", 32'(flags), 32'd0);

      // Call at the current floor opens the door in place; repeat call restarts the timer
      stop_q.push_back(3);
      send_req(3);
      wait_cond("here_door", W_DOOR, 0, 10);
      check("here_floor", 32'(current_floor), 32'd3);
      repeat (5) @(negedge clk);
      check("restart_open", 32'(open_door), 32'd1);
      send_req(3);
      check("restart_pending", 32'(pending), 32'd0);
      count_open(n);
      $display("[%0t] door open %0d clks after restart", $time, n);
      check("restart_len_in_9_12", 32'(n >= 9 && n <= 12), 32'd1);
      wait_cond("restart_idle", W_IDLE, 0, 20);

      // Asynchronous reset while moving at floor 4
      send_req(6);
      wait_cond("arst_at4", W_FLOOR, 4, 40);
      check("arst_moving", 32'(up), 32'd1);
      mon_en = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("arst_floor", 32'(current_floor), 32'd0);
      check("arst_pending", 32'(pending), 32'd0);
      check("arst_flags", 32'(flags), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;

      // Call for floor 0 while parked at 0
      stop_q.push_back(0);
      send_req(0);
      wait_cond("zero_door", W_DOOR, 0, 10);
      check("zero_floor", 32'(current_floor), 32'd0);
      wait_cond("zero_idle", W_IDLE, 0, 30);

      check("stops_left", 32'(stop_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
Parametrised elevator controller: latches multiple floor requests into a pending-call vector and serves them with SCAN ordering: keep travelling in the current direction while calls remain ahead, then reverse. It adds a timed door cycle, an over-weight hold and a rescue override. An internal prescaler paces movement. current_floor drives the existing seven-segment decoder externally.

Parameters:
NUM_FLOORS, 8, number of floors (2..16)
FLOOR_W, 4, floor index width, must be >= clog2(NUM_FLOORS)
TICK_DIV, 25000000, clk cycles per tick (>= 2)
TRAVEL_TICKS, 1, ticks per one-floor move (>= 1)
DOOR_TICKS, 3, ticks the door stays open (>= 1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
on  in  1  enable: when 0, requests are not latched and IDLE is not left
req_valid  in  1  one-clk request strobe
req_floor  in  FLOOR_W  requested floor, sampled with req_valid
over_weight  in  1  cabin load sensor
rescue  in  1  emergency override, level
current_floor  out  FLOOR_W  registered cabin position
pending  out  NUM_FLOORS  latched calls, bit i = floor i
up  out  1  moving up
down  out  1  moving down
open_door  out  1  door open
weight_alert  out  1  over-weight hold active
responce_rescue  out  1  rescue mode active

Behaviour:
- Reset (async): state IDLE, current_floor 0, pending 0, dir_up 1, prescaler and timers 0, all flag outputs 0. All outputs are registered.
- tick: one-clk pulse when the prescaler reaches TICK_DIV-1, then the prescaler wraps to 0. It runs freely from reset and is not resynchronised by requests.
- Request latch: req_valid && on && req_floor < NUM_FLOORS sets pending[req_floor] on the next clk. Out-of-range requests are ignored. A clear of the same bit in the same cycle (door opening at that floor) wins.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, HALT_WEIGHT, RESCUE.
- IDLE (on=1), checked every clk in this priority order:
  - over_weight: go to HALT_WEIGHT.
  - pending[current_floor]: go to DOOR_OPEN.
  - Call ahead in dir_up direction: move that way.
  - Call behind only: flip dir_up and move.
  - Otherwise: stay.
  - Latency: request strobe at IDLE, then up/down asserted 2 clk later.
- MOVE_UP / MOVE_DOWN:
  - up (or down) = 1.
  - Travel counter counts ticks; at TRAVEL_TICKS, current_floor is incremented (decremented) and the counter cleared.
  - If the new floor is pending: go to DOOR_OPEN and clear the bit. Otherwise continue.
  - current_floor saturates at 0 and NUM_FLOORS-1. It never wraps.
  - over_weight is ignored while moving.
- DOOR_OPEN:
  - open_door = 1, up = down = 0.
  - The door timer counts ticks; at DOOR_TICKS, go to IDLE.
  - A latched request for current_floor restarts the timer and does not set pending.
  - over_weight: go to HALT_WEIGHT.
- HALT_WEIGHT:
  - open_door = 1, weight_alert = 1.
  - Hold while over_weight = 1.
  - On release, go to DOOR_OPEN with the door timer cleared (full DOOR_TICKS).
- RESCUE:
  - Entered from any state on the clk after rescue = 1; highest priority, beats a simultaneous request.
  - On entry: pending cleared, up = down = open_door = 0, responce_rescue = 1, current_floor held.
  - Requests are ignored while in RESCUE.
  - When rescue falls, go to IDLE with travel and door timers cleared.
- on=0 mid-trip: the trip completes normally; only leaving IDLE is blocked.
- Reset mid-operation: immediate return to reset values. Pending calls are lost.

Decomposition:
- Shared package elevator_pkg holds:
  - the state enum;
  - default parameter constants;
  - a pending-ahead/behind helper function (mask above/below current_floor, OR-reduce).
- One sub-module: elevator_tick_gen. It is the prescaler with parameter TICK_DIV, inputs clk and reset, and a single output tick.

Test Plan:
All scenarios use TICK_DIV=4, TRAVEL_TICKS=1, DOOR_TICKS=3, NUM_FLOORS=8.
- Single trip: from floor 0, request 5. Then up=1 for 5 ticks, current_floor steps 1..5, open_door=1 for 3 ticks, pending=0, then IDLE with up=down=0.
- SCAN order: moving up from 2 with pending 6, request 4 and 1. Stops occur at 4, then 6, then 1. dir reverses only after 6; down=1 between 6 and 1.
- Over-weight: over_weight=1 during DOOR_OPEN at floor 3. Then weight_alert=1 and open_door held. Release leads to exactly 3 more ticks of open_door, then close.
- Rescue: rescue=1 while moving up at floor 3 with pending 7. Next clk: up=0, responce_rescue=1, pending=0. Drop rescue: IDLE at floor 3, no movement.
- Edges: req_floor=9 is ignored (pending unchanged). Request for floor 0 while IDLE at 0 gives DOOR_OPEN with no movement. Request for the current floor during DOOR_OPEN restarts the 3-tick timer.
- Reset: assert reset mid-move at floor 4. Asynchronous clear gives current_floor=0, pending=0, all flags 0.
